// File: rtl/ysyx_22050550_lsu_axi_gen2_if.sv
// ysyx_22050550_lsu_axi_gen2_if: request/response, D-cache and AXI4 bundle for the LSU
interface ysyx_22050550_lsu_axi_gen2_if #(
  parameter int XLEN = 64,
  parameter int AW = 64,
  parameter int TAG_W = 64
);
  localparam int NB = XLEN / 8;
  logic req_valid, req_ready, req_load, req_store;
  logic [AW-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0] req_func3;
  logic [TAG_W-1:0] req_tag;
  logic resp_valid, resp_ready, resp_fault;
  logic [XLEN-1:0] resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic cache_valid, cache_op, cache_dataok;
  logic [AW-1:0] cache_addr;
  logic [XLEN-1:0] cache_wdata, cache_rdata;
  logic [NB-1:0] cache_wmask;
  logic ar_valid, ar_ready;
  logic [AW-1:0] ar_addr;
  logic [2:0] ar_size;
  logic [7:0] ar_len;
  logic [1:0] ar_burst;
  logic r_valid, r_ready;
  logic [XLEN-1:0] r_data;
  logic [1:0] r_resp;
  logic aw_valid, aw_ready;
  logic [AW-1:0] aw_addr;
  logic [2:0] aw_size;
  logic [7:0] aw_len;
  logic [1:0] aw_burst;
  logic w_valid, w_ready, w_last;
  logic [XLEN-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic b_valid, b_ready;
  logic [1:0] b_resp;
  modport master (
    input req_valid, req_load, req_store, req_addr, req_wdata, req_func3, req_tag, resp_ready,
    input cache_rdata, cache_dataok, ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
    input b_valid, b_resp,
    output req_ready, resp_valid, resp_rdata, resp_tag, resp_fault,
    output cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
    output ar_valid, ar_addr, ar_size, ar_len, ar_burst, r_ready,
    output aw_valid, aw_addr, aw_size, aw_len, aw_burst, w_valid, w_data, w_strb, w_last, b_ready
  );
  modport slave (
    output req_valid, req_load, req_store, req_addr, req_wdata, req_func3, req_tag, resp_ready,
    output cache_rdata, cache_dataok, ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
    output b_valid, b_resp,
    input req_ready, resp_valid, resp_rdata, resp_tag, resp_fault,
    input cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
    input ar_valid, ar_addr, ar_size, ar_len, ar_burst, r_ready,
    input aw_valid, aw_addr, aw_size, aw_len, aw_burst, w_valid, w_data, w_strb, w_last, b_ready
  );
endinterface

// File: rtl/ysyx_22050550_lsu_axi_gen2.sv
// ysyx_22050550_lsu_axi_gen2: single-outstanding LSU, PMEM via D-cache, rest via AXI4; define LSU_MISALIGN_CHECK_EN to fault misaligned requests
module ysyx_22050550_lsu_axi_gen2 #(
  parameter int XLEN = 64,
  parameter int AW = 64,
  parameter int TAG_W = 64,
  parameter logic [AW-1:0] PMEM_BASE = AW'(64'h8000_0000),
  parameter logic [AW-1:0] PMEM_LIMIT = AW'(64'h8800_0000)
) (
  input logic clock,
  input logic reset,
  ysyx_22050550_lsu_axi_gen2_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int XB = $clog2(XLEN);
  typedef enum logic [2:0] {IDLE, CACHE, AR, R, AWW, B, RESP} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr_q;
  logic [XLEN-1:0] wdata_q, rdata_q, raw_in, sh, lmask, ld_ext;
  logic [2:0] func3_q;
  logic [TAG_W-1:0] tag_q;
  logic store_q, fault_q, aw_done, w_done, req_pmem, req_mis;
  logic [LW-1:0] off;
  logic [1:0] sz;
  logic [XB-1:0] sbit;
  assign off = addr_q[LW-1:0];
  assign sz = (32'(func3_q[1:0]) > LW) ? 2'(LW) : func3_q[1:0];
  assign sbit = XB'((8 << sz) - 1);
  assign req_pmem = bus.req_addr >= PMEM_BASE && bus.req_addr < PMEM_LIMIT;
`ifdef LSU_MISALIGN_CHECK_EN
  logic [LW-1:0] req_off;
  logic [1:0] req_sz;
  assign req_off = bus.req_addr[LW-1:0];
  assign req_sz = (32'(bus.req_func3[1:0]) > LW) ? 2'(LW) : bus.req_func3[1:0];
  // size-1 as a low-bit mask; wraps to all-ones for the full-word size
  assign req_mis = |(req_off & ((LW'(1) << req_sz) - LW'(1)));
`else
  assign req_mis = 1'b0;
`endif
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (bus.req_valid) state_n = (!(bus.req_load | bus.req_store) || req_mis) ? RESP :
                                          req_pmem ? CACHE : bus.req_load ? AR : AWW;
      CACHE: if (bus.cache_dataok) state_n = RESP;
      AR:    if (bus.ar_ready) state_n = R;
      R:     if (bus.r_valid) state_n = RESP;
      AWW:   if ((aw_done | bus.aw_ready) & (w_done | bus.w_ready)) state_n = B;
      B:     if (bus.b_valid) state_n = RESP;
      RESP:  if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.cache_valid = state == CACHE;
    bus.ar_valid = state == AR;
    bus.r_ready = state == R;
    bus.aw_valid = state == AWW && !aw_done;
    bus.w_valid = state == AWW && !w_done;
    bus.b_ready = state == B;
    bus.resp_valid = state == RESP;
  end
  always_comb begin
    raw_in = state == CACHE ? bus.cache_rdata : bus.r_data;
    sh = raw_in >> {off, 3'b000};
    lmask = {XLEN{1'b1}} >> (XLEN - (8 << sz));
    ld_ext = (sh & lmask) | ((!func3_q[2] && sh[sbit]) ? ~lmask : '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      tag_q <= '0;
      fault_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        func3_q <= bus.req_func3;
        tag_q <= bus.req_tag;
        store_q <= bus.req_store & ~bus.req_load;
        rdata_q <= '0;
        fault_q <= req_mis & (bus.req_load | bus.req_store);
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (state == CACHE && bus.cache_dataok) rdata_q <= store_q ? '0 : ld_ext;
      if (state == R && bus.r_valid) begin
        rdata_q <= ld_ext;
        fault_q <= |bus.r_resp;
      end
      if (state == AWW) begin
        aw_done <= aw_done | bus.aw_ready;
        w_done <= w_done | bus.w_ready;
      end
      if (state == B && bus.b_valid) fault_q <= |bus.b_resp;
    end
  end
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_tag = tag_q;
  assign bus.resp_fault = fault_q;
  assign bus.cache_op = store_q;
  assign bus.cache_addr = addr_q;
  assign bus.cache_wdata = wdata_q << {off, 3'b000};
  assign bus.cache_wmask = NB'((1 << (1 << sz)) - 1) << off;
  assign bus.ar_addr = addr_q;
  assign bus.ar_size = {1'b0, sz};
  assign bus.ar_len = 8'd0;
  assign bus.ar_burst = 2'b01;
  assign bus.aw_addr = addr_q;
  assign bus.aw_size = {1'b0, sz};
  assign bus.aw_len = 8'd0;
  assign bus.aw_burst = 2'b01;
  assign bus.w_data = bus.cache_wdata;
  assign bus.w_strb = bus.cache_wmask;
  assign bus.w_last = 1'b1;
endmodule

// File: tb/tb_ysyx_22050550_lsu_axi_gen2.sv
// tb_ysyx_22050550_lsu_axi_gen2: randomized transactions against a byte-level LSU model
module tb_ysyx_22050550_lsu_axi_gen2;
  localparam logic [63:0] BASE = 64'h8000_0000, LIMIT = 64'h8800_0000;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  ysyx_22050550_lsu_axi_gen2_if #(.XLEN(64), .AW(64), .TAG_W(64)) bus ();
  ysyx_22050550_lsu_axi_gen2 dut (.clock(clock), .reset(reset), .bus(bus));
  int checks = 0, failures = 0, cyc = 0, t_req, t_resp, exp_kind;
  bit chk_en = 0, active = 0, resp_allowed = 0, to, exp_store, exp_fault, last_fault;
  logic [63:0] exp_addr, exp_wdata, exp_rdata, exp_tag, last_rdata, last_wdata;
  logic [2:0] exp_size;
  logic [7:0] exp_strb, last_strb;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [63:0] m_load(logic [63:0] raw, int off, int n, bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) v[8*i+:8] = raw[8*(off+i)+:8];
    if (!uns && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i+:8] = 8'hFF;
    return v;
  endfunction
  function automatic bit sig(int k);
    case (k)
      0: return bus.ar_valid;
      1: return bus.r_ready;
      2: return bus.b_ready;
      3: return bus.resp_valid;
      default: return bus.cache_valid;
    endcase
  endfunction
  task automatic wait_sig(input int k, input string nm);
    int t = 0;
    while (!sig(k) && t < 40) begin
      step();
      t++;
    end
    chk({nm, "_timeout"}, 64'(sig(k)), 64'd1);
    to = !sig(k);
  endtask
  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_load = 0; bus.req_store = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_func3 = 0; bus.req_tag = 0; bus.resp_ready = 0; bus.cache_rdata = 0; bus.cache_dataok = 0;
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = 0; bus.r_resp = 0; bus.aw_ready = 0;
    bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = 0;
  endtask
  task automatic recover();
    chk_en = 0; active = 0; resp_allowed = 0;
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    chk_en = 1;
  endtask
  always @(negedge clock) if (chk_en) begin
    if (!active)
      chk("idle_outs", 64'({bus.cache_valid, bus.ar_valid, bus.aw_valid, bus.w_valid, bus.resp_valid, bus.req_ready}), 64'd1);
    else begin
      if (bus.cache_valid) begin
        chk("cache_kind", 64'(exp_kind), 64'd1);
        chk("cache_addr", bus.cache_addr, exp_addr);
        chk("cache_op", 64'(bus.cache_op), 64'(exp_store));
        if (exp_store) begin
          chk("cache_wdata", bus.cache_wdata, exp_wdata);
          chk("cache_wmask", 64'(bus.cache_wmask), 64'(exp_strb));
        end
      end
      if (bus.ar_valid) begin
        chk("ar_kind", 64'(exp_kind), 64'd2);
        chk("ar_addr", bus.ar_addr, exp_addr);
        chk("ar_size", 64'(bus.ar_size), 64'(exp_size));
        chk("ar_len_burst", 64'({bus.ar_len, bus.ar_burst}), 64'd1);
      end
      if (bus.aw_valid) begin
        chk("aw_kind", 64'(exp_kind), 64'd3);
        chk("aw_addr", bus.aw_addr, exp_addr);
        chk("aw_size", 64'(bus.aw_size), 64'(exp_size));
        chk("aw_len_burst", 64'({bus.aw_len, bus.aw_burst}), 64'd1);
      end
      if (bus.w_valid) begin
        chk("w_kind", 64'(exp_kind), 64'd3);
        chk("w_data", bus.w_data, exp_wdata);
        chk("w_strb_last", 64'({bus.w_strb, bus.w_last}), 64'({exp_strb, 1'b1}));
      end
      if (bus.resp_valid) begin
        chk("resp_early", 64'(resp_allowed), 64'd1);
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_tag", bus.resp_tag, exp_tag);
        chk("resp_fault", 64'(bus.resp_fault), 64'(exp_fault));
        chk("resp_req_ready", 64'(bus.req_ready), 64'd0);
      end
    end
  end
  task automatic xact(input int op, input logic [63:0] a, input logic [63:0] wd, input logic [2:0] f3,
                      input logic [63:0] tg, input logic [63:0] raw, input logic [1:0] rsp,
                      input int da, input int dw, input int db, input int dr);
    int off, n;
    bit ld, st, pm, ad, wdn;
    off = int'(a[2:0]);
    n = 1 << f3[1:0];
    ld = op == 1 || op == 3;
    st = op == 2;
    pm = a >= BASE && a < LIMIT;
    exp_addr = a; exp_size = {1'b0, f3[1:0]}; exp_store = st; exp_tag = tg;
    exp_wdata = wd << (8 * off);
    exp_strb = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) exp_strb[off+i] = 1'b1;
    exp_kind = !(ld || st) ? 0 : pm ? 1 : ld ? 2 : 3;
    exp_rdata = ld ? m_load(raw, off, n, f3[2]) : 64'd0;
    exp_fault = exp_kind >= 2 && rsp != 0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((ld || st) && (off % n) != 0) begin
      exp_kind = 0; exp_fault = 1; exp_rdata = 0;
    end
`endif
    to = 0; resp_allowed = exp_kind == 0; active = 1;
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1; bus.req_load = op[0]; bus.req_store = op[1]; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_func3 = f3; bus.req_tag = tg;
    t_req = cyc;
    step();
    bus.req_valid = 0;
    case (exp_kind)
      1: begin
        repeat (da) step();
        wait_sig(4, "cache");
        if (to) begin recover(); return; end
        bus.cache_rdata = raw; bus.cache_dataok = 1; resp_allowed = 1;
        step();
        bus.cache_dataok = 0;
      end
      2: begin
        repeat (da) step();
        bus.ar_ready = 1;
        wait_sig(0, "ar");
        if (to) begin recover(); return; end
        step();
        bus.ar_ready = 0;
        repeat (db) step();
        bus.r_valid = 1; bus.r_data = raw; bus.r_resp = rsp; resp_allowed = 1;
        wait_sig(1, "r");
        if (to) begin recover(); return; end
        step();
        bus.r_valid = 0;
      end
      3: begin
        ad = 0; wdn = 0;
        for (int t = 0; t < 40 && !(ad && wdn); t++) begin
          bus.aw_ready = t >= da && !ad;
          bus.w_ready = t >= dw && !wdn;
          if (bus.w_valid && bus.w_ready) begin
            last_wdata = bus.w_data; last_strb = bus.w_strb;
          end
          ad |= bus.aw_valid && bus.aw_ready;
          wdn |= bus.w_valid && bus.w_ready;
          step();
        end
        bus.aw_ready = 0; bus.w_ready = 0;
        chk("aww_timeout", 64'(ad && wdn), 64'd1);
        if (!(ad && wdn)) begin recover(); return; end
        repeat (db) step();
        bus.b_valid = 1; bus.b_resp = rsp; resp_allowed = 1;
        wait_sig(2, "b");
        if (to) begin recover(); return; end
        step();
        bus.b_valid = 0;
      end
      default: ;
    endcase
    wait_sig(3, "resp");
    if (to) begin recover(); return; end
    t_resp = cyc; last_rdata = bus.resp_rdata; last_fault = bus.resp_fault;
    repeat (dr) step();
    bus.resp_ready = 1;
    step();
    bus.resp_ready = 0; active = 0; resp_allowed = 0;
    chk("post_resp_idle", 64'({bus.resp_valid, bus.req_ready}), 64'd1);
  endtask
  initial begin
    int op;
    logic [63:0] a;
    idle_inputs();
    reset = 1;
    repeat (2) step();
    reset = 0;
    chk("rst_outs", 64'({bus.cache_valid, bus.ar_valid, bus.r_ready, bus.aw_valid, bus.w_valid,
                         bus.b_ready, bus.resp_valid, bus.req_ready}), 64'd1);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_tag", bus.resp_tag, 64'd0);
    chk("rst_fault", 64'(bus.resp_fault), 64'd0);
    chk_en = 1;
    xact(1, 64'h8000_0010, 64'd0, 3'b011, 64'h11, 64'h1122334455667788, 2'b00, 0, 0, 0, 0);
    chk("ld_hit_rdata", last_rdata, 64'h1122334455667788);
    chk("ld_hit_latency", 64'(t_resp - t_req), 64'd2);
    xact(1, 64'h1000_0003, 64'd0, 3'b000, 64'h22, 64'h0000_0000_8000_0000, 2'b00, 3, 0, 1, 0);
    chk("lb_mmio_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    xact(2, 64'h1000_0006, 64'hBEEF, 3'b001, 64'h33, 64'd0, 2'b00, 2, 0, 2, 0);
    chk("sh_w_data", last_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_w_strb", 64'(last_strb), 64'hC0);
    chk("sh_rdata", last_rdata, 64'd0);
    xact(1, 64'h1000_0000, 64'd0, 3'b010, 64'h44, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 0, 0, 4);
    chk("lw_slverr_fault", 64'(last_fault), 64'd1);
    chk_en = 0;
    bus.req_valid = 1; bus.req_load = 1; bus.req_store = 0; bus.req_addr = 64'h1000_0000;
    bus.req_func3 = 3'b010; bus.req_tag = 64'h77;
    step();
    bus.req_valid = 0; bus.ar_ready = 1;
    step();
    bus.ar_ready = 0;
    chk("in_r_ready", 64'(bus.r_ready), 64'd1);
    reset = 1;
    step();
    reset = 0;
    chk("rst_r_ready", 64'(bus.r_ready), 64'd0);
    chk("rst_r_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_r_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_r_tag", bus.resp_tag, 64'd0);
    chk_en = 1;
`ifdef LSU_MISALIGN_CHECK_EN
    xact(1, 64'h8000_0002, 64'd0, 3'b010, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 0);
    chk("misalign_fault", 64'(last_fault), 64'd1);
    chk("misalign_rdata", last_rdata, 64'd0);
`endif
    repeat (300) begin
      op = $urandom_range(0, 9);
      op = op == 0 ? 0 : op == 1 ? 3 : op < 6 ? 1 : 2;
      case ($urandom_range(0, 4))
        0, 1: a = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
        2: a = 64'($urandom_range(0, 32'h7FFF_FFFF));
        3: a = LIMIT + 64'($urandom_range(0, 255));
        default: a = ($urandom_range(0, 1) ? BASE : LIMIT) - 64'd4 + 64'($urandom_range(0, 7));
      endcase
      xact(op, a, {$urandom, $urandom}, 3'($urandom_range(0, 7)), {$urandom, $urandom},
           {$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
